// File: rtl/crosswalk_scheduler_pkg.sv
// Shared interval codes and scheduler state encoding, also used by the main FSM.
package crosswalk_scheduler_pkg;

    localparam logic [1:0] INTERVAL_WALK  = 2'b11;
    localparam logic [1:0] INTERVAL_CLEAR = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START_WALK,
        S_WALK,
        S_START_CLEAR,
        S_CLEAR,
        S_DONE
    } state_t;

endpackage

// File: rtl/crosswalk_scheduler_rr_arbiter_n.sv
// Combinational round-robin pick: first set pending bit at or after i_ptr, wrapping modulo N.
module rr_arbiter_n #(
    parameter int N = 4
) (
    input  logic [N-1:0]         i_pending,
    input  logic [$clog2(N)-1:0] i_ptr,
    output logic [N-1:0]         o_grant,
    output logic                 o_valid
);

    localparam int PW = $clog2(N);

    logic [PW:0]   w_sum [N];
    logic [PW-1:0] w_idx [N];

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_idx
            assign w_sum[gi] = {1'b0, i_ptr} + (PW+1)'(gi);
            assign w_idx[gi] = (w_sum[gi] >= (PW+1)'(N)) ? PW'(w_sum[gi] - (PW+1)'(N))
                                                          : w_sum[gi][PW-1:0];
        end
    endgenerate

    always_comb begin
        o_grant = '0;
        o_valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!o_valid && i_pending[w_idx[k]]) begin
                o_grant[w_idx[k]] = 1'b1;
                o_valid           = 1'b1;
            end
        end
    end

endmodule

// File: rtl/crosswalk_scheduler.sv
// Shares the countdown timer and walk window among N crosswalks: one WALK then CLEAR
// phase per served crosswalk, chosen round-robin from the latched requests.
module crosswalk_scheduler
    import crosswalk_scheduler_pkg::state_t,
           crosswalk_scheduler_pkg::S_IDLE,
           crosswalk_scheduler_pkg::S_START_WALK,
           crosswalk_scheduler_pkg::S_WALK,
           crosswalk_scheduler_pkg::S_START_CLEAR,
           crosswalk_scheduler_pkg::S_CLEAR,
           crosswalk_scheduler_pkg::S_DONE;
#(
    parameter int         N              = 4,
    parameter logic [1:0] INTERVAL_WALK  = crosswalk_scheduler_pkg::INTERVAL_WALK,
    parameter logic [1:0] INTERVAL_CLEAR = crosswalk_scheduler_pkg::INTERVAL_CLEAR
) (
    input  logic         clk,
    input  logic         Reset,
    input  logic [N-1:0] Walk_Req,
    input  logic         win_gnt,
    input  logic         expired,
    output logic         win_req,
    output logic         tmr_own,
    output logic [1:0]   interval,
    output logic         start_timer,
    output logic [N-1:0] walk_grant,
    output logic [N-1:0] clear_active,
    output logic [N-1:0] pending,
    output logic         protocol_err
);

    localparam int            PW   = $clog2(N);
    localparam logic [PW-1:0] LAST = PW'(N - 1);

    state_t        r_state;
    logic [N-1:0]  r_pending;
    logic [N-1:0]  r_win_oh;
    logic [PW-1:0] r_win_idx;
    logic [PW-1:0] r_rr_ptr;
    logic          r_first;
    logic          r_protocol_err;

    logic [N-1:0]  w_arb_oh;
    logic          w_arb_valid;
    logic [PW-1:0] w_arb_idx;
    logic [N-1:0]  w_pend_clr;

    rr_arbiter_n #(.N(N)) u_arb (
        .i_pending (r_pending),
        .i_ptr     (r_rr_ptr),
        .o_grant   (w_arb_oh),
        .o_valid   (w_arb_valid)
    );

    always_comb begin
        w_arb_idx = '0;
        for (int k = 0; k < N; k++) begin
            if (w_arb_oh[k]) w_arb_idx = k[PW-1:0];
        end
    end

    assign w_pend_clr = (r_state == S_START_WALK) ? r_win_oh : '0;

    // r_first masks expired for one cycle after each timer load (reload latency).
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_state        <= S_IDLE;
            r_pending      <= '0;
            r_win_oh       <= '0;
            r_win_idx      <= '0;
            r_rr_ptr       <= '0;
            r_first        <= 1'b0;
            r_protocol_err <= 1'b0;
        end else begin
            r_pending <= (r_pending & ~w_pend_clr) | Walk_Req;
            r_first   <= 1'b0;
            if (tmr_own && !win_gnt) r_protocol_err <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (win_gnt && w_arb_valid) begin
                        r_state   <= S_START_WALK;
                        r_win_oh  <= w_arb_oh;
                        r_win_idx <= w_arb_idx;
                    end
                end
                S_START_WALK: begin
                    r_state <= S_WALK;
                    r_first <= 1'b1;
                end
                S_WALK: if (expired && !r_first) r_state <= S_START_CLEAR;
                S_START_CLEAR: begin
                    r_state <= S_CLEAR;
                    r_first <= 1'b1;
                end
                S_CLEAR: if (expired && !r_first) r_state <= S_DONE;
                S_DONE: begin
                    r_state  <= S_IDLE;
                    r_rr_ptr <= (r_win_idx == LAST) ? '0 : r_win_idx + 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        win_req      = 1'b1;
        tmr_own      = 1'b0;
        interval     = 2'b00;
        start_timer  = 1'b0;
        walk_grant   = '0;
        clear_active = '0;
        case (r_state)
            S_IDLE: win_req = |r_pending;
            S_START_WALK: begin
                tmr_own     = 1'b1;
                interval    = INTERVAL_WALK;
                start_timer = 1'b1;
                walk_grant  = r_win_oh;
            end
            S_WALK: begin
                tmr_own    = 1'b1;
                interval   = INTERVAL_WALK;
                walk_grant = r_win_oh;
            end
            S_START_CLEAR: begin
                tmr_own      = 1'b1;
                interval     = INTERVAL_CLEAR;
                start_timer  = 1'b1;
                clear_active = r_win_oh;
            end
            S_CLEAR: begin
                tmr_own      = 1'b1;
                interval     = INTERVAL_CLEAR;
                clear_active = r_win_oh;
            end
            S_DONE:  win_req = 1'b0;
            default: win_req = 1'b0;
        endcase
    end

    assign pending      = r_pending;
    assign protocol_err = r_protocol_err;

endmodule

// File: tb/tb_crosswalk_scheduler.sv
// Directed bench for crosswalk_scheduler with a simple timer model (WALK=4, CLEAR=2 ticks).
module tb_crosswalk_scheduler;

    localparam int N = 4;

    logic         clk      = 1'b0;
    logic         Reset    = 1'b1;
    logic [N-1:0] Walk_Req = '0;
    logic         win_gnt  = 1'b0;
    logic         expired;
    logic         win_req;
    logic         tmr_own;
    logic [1:0]   interval;
    logic         start_timer;
    logic [N-1:0] walk_grant;
    logic [N-1:0] clear_active;
    logic [N-1:0] pending;
    logic         protocol_err;

    int checks   = 0;
    int failures = 0;

    crosswalk_scheduler #(.N(N)) dut (
        .clk          (clk),
        .Reset        (Reset),
        .Walk_Req     (Walk_Req),
        .win_gnt      (win_gnt),
        .expired      (expired),
        .win_req      (win_req),
        .tmr_own      (tmr_own),
        .interval     (interval),
        .start_timer  (start_timer),
        .walk_grant   (walk_grant),
        .clear_active (clear_active),
        .pending      (pending),
        .protocol_err (protocol_err)
    );

    always #5 clk = ~clk;

    // Timer model: load on start_timer, count down, expired while the count is zero.
    int unsigned tcount;
    always @(posedge clk or posedge Reset) begin
        if (Reset)              tcount <= 0;
        else if (start_timer)   tcount <= (interval == 2'b11) ? 4 : 2;
        else if (tcount != 0)   tcount <= tcount - 1;
    end
    assign expired = (tcount == 0);

    always @(negedge clk) begin
        if (!Reset) begin
            checks++;
            if ((walk_grant != 0 && clear_active != 0) || !$onehot0(walk_grant) || !$onehot0(clear_active)) begin
                failures++;
                $display("FAIL exclusive t=%0t walk_grant=%b clear_active=%b", $time, walk_grant, clear_active);
            end
        end
    end

    typedef struct packed {
        logic [3:0] wr;
        logic       gnt;
        logic [3:0] wg;
        logic [3:0] ca;
        logic       wreq;
        logic       own;
        logic       st;
        logic [1:0] intv;
        logic [3:0] pend;
    } vec_t;

    vec_t tbl [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end else begin
            $display("ok   %s value=%h", name, act);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        Reset    = 1'b1;
        Walk_Req = '0;
        win_gnt  = 1'b0;
        @(negedge clk);
        Reset = 1'b0;
    endtask

    task automatic next_walk(output logic [3:0] g);
        int n;
        n = 0;
        while (walk_grant != 0 && n < 200) begin @(negedge clk); n++; end
        while (walk_grant == 0 && n < 200) begin @(negedge clk); n++; end
        g = walk_grant;
        if (n >= 200) begin
            checks++;
            failures++;
            $display("FAIL next_walk timeout walk_grant=%b", walk_grant);
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (tmr_own && n < 200) begin @(negedge clk); n++; end
        @(negedge clk);
        @(negedge clk);
        check(name, {26'd0, win_req, tmr_own, pending}, 32'd0);
    endtask

    initial begin
        logic [3:0] g;
        int n;

        tbl[0]  = {4'b0100, 1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 2'b00, 4'b0100};
        tbl[1]  = {4'b0000, 1'b1, 4'b0100, 4'b0000, 1'b1, 1'b1, 1'b1, 2'b11, 4'b0100};
        for (int i = 2; i <= 6; i++)
            tbl[i] = {4'b0000, 1'b1, 4'b0100, 4'b0000, 1'b1, 1'b1, 1'b0, 2'b11, 4'b0000};
        tbl[7]  = {4'b0000, 1'b1, 4'b0000, 4'b0100, 1'b1, 1'b1, 1'b1, 2'b10, 4'b0000};
        for (int i = 8; i <= 10; i++)
            tbl[i] = {4'b0000, 1'b1, 4'b0000, 4'b0100, 1'b1, 1'b1, 1'b0, 2'b10, 4'b0000};
        tbl[11] = {4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 2'b00, 4'b0000};
        tbl[12] = {4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 2'b00, 4'b0000};

        // Reset holds everything at zero even with requests driven.
        Walk_Req = 4'b1111;
        repeat (2) @(negedge clk);
        check("reset_state", {10'd0, walk_grant, clear_active, win_req, tmr_own, start_timer,
                              interval, pending, protocol_err}, 32'd0);
        Walk_Req = '0;
        Reset    = 1'b0;

        // Single request, cycle by cycle.
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            Walk_Req = tbl[i].wr;
            win_gnt  = tbl[i].gnt;
            @(posedge clk);
            #1;
            check($sformatf("single_step%0d", i),
                  {14'd0, walk_grant, clear_active, win_req, tmr_own, start_timer, interval, pending, protocol_err},
                  {14'd0, tbl[i].wg, tbl[i].ca, tbl[i].wreq, tbl[i].own, tbl[i].st, tbl[i].intv, tbl[i].pend, 1'b0});
        end

        // Round-robin order from a fresh pointer.
        do_reset();
        @(negedge clk); Walk_Req = 4'b1011; win_gnt = 1'b1;
        @(negedge clk); Walk_Req = 4'b0000;
        next_walk(g); check("rr_first",  {28'd0, g}, 32'h1);
        next_walk(g); check("rr_second", {28'd0, g}, 32'h2);
        next_walk(g); check("rr_third",  {28'd0, g}, 32'h8);
        wait_idle("rr_idle");

        // Pointer back at 0, then async reset in the middle of crosswalk 1's WALK.
        @(negedge clk); Walk_Req = 4'b1111;
        @(negedge clk); Walk_Req = 4'b0000;
        next_walk(g); check("rr_ptr_wrap", {28'd0, g}, 32'h1);
        next_walk(g); check("rr_after_0",  {28'd0, g}, 32'h2);
        #2 Reset = 1'b1;
        #1 check("async_reset", {12'd0, walk_grant, clear_active, win_req, tmr_own, start_timer,
                                 interval, pending}, 32'd0);
        @(negedge clk); Reset = 1'b0;
        @(negedge clk); Walk_Req = 4'b1001;
        @(negedge clk); Walk_Req = 4'b0000;
        next_walk(g); check("post_reset_first",  {28'd0, g}, 32'h1);
        next_walk(g); check("post_reset_second", {28'd0, g}, 32'h8);
        wait_idle("post_reset_idle");

        // Re-request during own WALK goes behind the other waiting crosswalk.
        do_reset();
        @(negedge clk); Walk_Req = 4'b0010; win_gnt = 1'b1;
        @(negedge clk); Walk_Req = 4'b0000;
        next_walk(g); check("rereq_first", {28'd0, g}, 32'h2);
        @(negedge clk); @(negedge clk); Walk_Req = 4'b0110;
        @(negedge clk); Walk_Req = 4'b0000;
        check("rereq_pending", {28'd0, pending}, 32'h6);
        next_walk(g); check("rereq_second", {28'd0, g}, 32'h4);
        next_walk(g); check("rereq_third",  {28'd0, g}, 32'h2);
        wait_idle("rereq_idle");

        // Waiting for the window, then one-cycle grant latency.
        do_reset();
        @(negedge clk); Walk_Req = 4'b0001;
        @(negedge clk); Walk_Req = 4'b0000;
        repeat (20) @(negedge clk);
        check("window_wait", {26'd0, win_req, tmr_own, walk_grant}, {26'd0, 1'b1, 1'b0, 4'b0000});
        win_gnt = 1'b1;
        @(posedge clk); #1;
        check("window_latency", {27'd0, walk_grant, start_timer}, {27'd0, 4'b0001, 1'b1});

        // Revoke the window at the start of CLEAR: phase still completes, error sticks.
        n = 0;
        while (clear_active == 0 && n < 200) begin @(negedge clk); n++; end
        win_gnt = 1'b0;
        n = 0;
        while (clear_active != 0 && n < 20) begin @(negedge clk); n++; end
        check("revoke_clear_len", n, 32'd4);
        check("revoke_done", {29'd0, win_req, tmr_own, protocol_err}, 32'h1);
        repeat (5) @(negedge clk);
        check("revoke_sticky", {31'd0, protocol_err}, 32'h1);
        do_reset();
        check("revoke_reset", {31'd0, protocol_err}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
